// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_FILL     = 2'd1,
    ST_HUNT     = 2'd2
  } det_state_t;

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with sticky saturation flag; clear wins over hold but not over a same-cycle increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
      sat   <= inc && (W == 1);
    end else if (inc && !sat) begin
      count <= count + W'(1);
      sat   <= (count == CNT_MAX - W'(1));
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial pattern detector with registered match pulse and saturating match counter.
//   state    | meaning
//   DISABLED | en low; history and fill held clear
//   FILL     | collecting the first len bits since enable/config/non-overlap match
//   HUNT     | history holds len valid bits; every beat is compared
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1001),
  parameter int                 RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b1,
  localparam int                LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               data_valid,
  input  logic               data_in,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  input  logic               clear_count
);

  det_state_t         state;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] history_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q;
  logic               overlap_q;

  logic               cfg_ok;
  logic               beat;
  logic               compare;
  logic               match;
  logic [MAX_LEN-1:0] history_nx;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_inc;

  assign cfg_ok     = cfg_we && (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  // A config write always steals the data beat of the same cycle.
  assign beat       = en && data_valid && !cfg_we;
  assign history_nx = {history_q[MAX_LEN-2:0], data_in};
  assign fill_inc   = fill_q + LEN_W'(1);
  assign compare    = beat && ((state == ST_HUNT) || (fill_inc >= len_q));
  assign match      = compare && (((history_nx ^ pattern_q) & mask) == '0);

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_DISABLED;
      pattern_q <= RST_PATTERN;
      len_q     <= LEN_W'(RST_LEN);
      overlap_q <= RST_OVERLAP;
      history_q <= '0;
      fill_q    <= '0;
      detected  <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      detected <= match;
      cfg_err  <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        pattern_q <= cfg_pattern;
        len_q     <= cfg_len;
        overlap_q <= cfg_overlap;
        history_q <= '0;
        fill_q    <= '0;
        state     <= en ? ST_FILL : ST_DISABLED;
      end else if (!en) begin
        history_q <= '0;
        fill_q    <= '0;
        state     <= ST_DISABLED;
      end else if (beat) begin
        history_q <= history_nx;
        if (match && !overlap_q) begin
          fill_q <= '0;
          state  <= ST_FILL;
        end else if (compare) begin
          fill_q <= len_q;
          state  <= ST_HUNT;
        end else begin
          fill_q <= fill_inc;
          state  <= ST_FILL;
        end
      end else if (state == ST_DISABLED) begin
        state <= ST_FILL;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (clear_count),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector (MAX_LEN=8, CNT_W=2).
module tb_seq_pattern_detector;
  import seq_det_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = len_w(MAX_LEN);

  logic               clk = 1'b0;
  logic               reset;
  logic               en;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               data_valid;
  logic               data_in;
  logic               detected;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;
  logic               clear_count;

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_pattern_detector #(
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cfg_err    (cfg_err),
    .data_valid (data_valid),
    .data_in    (data_in),
    .detected   (detected),
    .match_count(match_count),
    .count_sat  (count_sat),
    .clear_count(clear_count)
  );

  task automatic drive_beat(input logic b, input logic exp_det);
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = b;
    exp_q.push_back(exp_det);
    @(posedge clk);
    #1;
    data_valid  = 1'b0;
    clear_count = 1'b0;
  endtask

  task automatic drive_cfg(input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                           input logic ov);
    @(negedge clk);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ov;
    @(posedge clk);
    #1;
    cfg_we     = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_count = 1'b1;
    @(posedge clk);
    #1;
    clear_count = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0;
    cfg_overlap = 1'b0; data_valid = 1'b0; data_in = 1'b0; clear_count = 1'b0;
    idle(2);
    checks++;
    if ({detected, cfg_err, match_count, count_sat} !== '0) begin
      failures++;
      $display("FAIL reset_outputs det=%b err=%b cnt=%0d sat=%b want all 0",
               detected, cfg_err, match_count, count_sat);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_default_overlap();
    logic [6:0] bits = 7'b1001001;
    logic [6:0] exp  = 7'b0001001;
    logic want;
    @(negedge clk); en = 1'b1;
    idle(1);
    for (int i = 6; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL default_beat%0d det=%b want=%b", 7 - i, detected, want);
      end
      if (i == 5) begin
        for (int g = 0; g < 3; g++) begin
          idle(1);
          checks++;
          if (detected !== 1'b0) begin
            failures++;
            $display("FAIL default_gap%0d det=%b want=0", g, detected);
          end
        end
      end
    end
    checks++;
    if (match_count !== 2'd2 || count_sat !== 1'b0) begin
      failures++;
      $display("FAIL default_count cnt=%0d sat=%b want 2/0", match_count, count_sat);
    end
  endtask

  task automatic test_no_overlap();
    logic [6:0] bits = 7'b1001001;
    logic [6:0] exp  = 7'b0001000;
    logic want;
    pulse_clear();
    checks++;
    if (match_count !== 2'd0) begin
      failures++;
      $display("FAIL clear_only cnt=%0d want 0", match_count);
    end
    drive_cfg(8'b1001, 4'd4, 1'b0);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL nooverlap_cfg_err err=%b want 0", cfg_err);
    end
    for (int i = 6; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL nooverlap_beat%0d det=%b want=%b", 7 - i, detected, want);
      end
    end
    checks++;
    if (match_count !== 2'd1) begin
      failures++;
      $display("FAIL nooverlap_count cnt=%0d want 1", match_count);
    end
  endtask

  task automatic test_len6();
    logic [8:0] bits = 9'b110110110;
    logic [8:0] exp  = 9'b000001001;
    logic want;
    pulse_clear();
    drive_cfg(8'b00110110, 4'd6, 1'b1);
    for (int i = 8; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL len6_beat%0d det=%b want=%b", 9 - i, detected, want);
      end
    end
    checks++;
    if (match_count !== 2'd2) begin
      failures++;
      $display("FAIL len6_count cnt=%0d want 2", match_count);
    end
  endtask

  task automatic test_cfg_err();
    logic [3:0] bits = 4'b1001;
    logic [3:0] exp  = 4'b0001;
    logic want;
    drive_cfg(8'b1001, 4'd4, 1'b1);
    drive_cfg(8'hFF, 4'd0, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL cfg_err_len0 err=%b want 1", cfg_err);
    end
    idle(1);
    checks++;
    if (cfg_err !== 1'b0) begin
      failures++;
      $display("FAIL cfg_err_pulse_width err=%b want 0", cfg_err);
    end
    drive_cfg(8'hFF, 4'd9, 1'b0);
    checks++;
    if (cfg_err !== 1'b1) begin
      failures++;
      $display("FAIL cfg_err_len9 err=%b want 1", cfg_err);
    end
    for (int i = 3; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL cfg_err_keep_beat%0d det=%b want=%b", 4 - i, detected, want);
      end
    end
  endtask

  task automatic test_cfg_collision();
    logic [5:0] bits = 6'b001001;
    logic [5:0] exp  = 6'b000001;
    logic want;
    @(negedge clk);
    data_valid = 1'b1;
    data_in    = 1'b1;
    drive_cfg(8'b1001, 4'd4, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL collision_beat%0d det=%b want=%b", 6 - i, detected, want);
      end
    end
  endtask

  task automatic test_saturation();
    logic [5:0] bits = 6'b110111;
    logic [5:0] exp  = 6'b110111;
    logic want;
    pulse_clear();
    drive_cfg(8'b1, 4'd1, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL sat_beat%0d det=%b want=%b", 6 - i, detected, want);
      end
    end
    checks++;
    if (match_count !== 2'd3 || count_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_hold cnt=%0d sat=%b want 3/1", match_count, count_sat);
    end
    @(negedge clk);
    clear_count = 1'b1;
    drive_beat(1'b1, 1'b1);
    want = exp_q.pop_front();
    checks++;
    if (detected !== want || match_count !== 2'd1 || count_sat !== 1'b0) begin
      failures++;
      $display("FAIL clear_with_match det=%b cnt=%0d sat=%b want %b/1/0",
               detected, match_count, count_sat, want);
    end
  endtask

  task automatic test_enable_drop();
    logic [3:0] bits = 4'b1000;
    logic [3:0] exp  = 4'b0000;
    logic want;
    drive_cfg(8'b1001, 4'd4, 1'b1);
    pulse_clear();
    for (int i = 3; i >= 1; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL endrop_pre_beat%0d det=%b want=%b", 4 - i, detected, want);
      end
    end
    @(negedge clk); en = 1'b0;
    idle(1);
    drive_beat(1'b1, 1'b0);
    want = exp_q.pop_front();
    checks++;
    if (detected !== want) begin
      failures++;
      $display("FAIL endrop_disabled_beat det=%b want=%b", detected, want);
    end
    @(negedge clk); en = 1'b1;
    idle(1);
    bits = 4'b1001;
    exp  = 4'b0001;
    for (int i = 3; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL endrop_post_beat%0d det=%b want=%b", 4 - i, detected, want);
      end
    end
    checks++;
    if (match_count !== 2'd1) begin
      failures++;
      $display("FAIL endrop_count cnt=%0d want 1", match_count);
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] bits = 4'b0110;
    logic [3:0] exp  = 4'b0001;
    logic want;
    drive_cfg(8'b0110, 4'd4, 1'b1);
    for (int i = 3; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL areset_pre_beat%0d det=%b want=%b", 4 - i, detected, want);
      end
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({detected, cfg_err, match_count, count_sat} !== '0) begin
      failures++;
      $display("FAIL async_reset det=%b err=%b cnt=%0d sat=%b want all 0",
               detected, cfg_err, match_count, count_sat);
    end
    @(negedge clk); reset = 1'b0;
    idle(1);
    bits = 4'b1001;
    for (int i = 3; i >= 0; i--) begin
      drive_beat(bits[i], exp[i]);
      want = exp_q.pop_front();
      checks++;
      if (detected !== want) begin
        failures++;
        $display("FAIL areset_default_beat%0d det=%b want=%b", 4 - i, detected, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_no_overlap();
    test_len6();
    test_cfg_err();
    test_cfg_collision();
    test_saturation();
    test_enable_drop();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
